// File: rtl/mem_stage_if.sv
// Pipeline/memory bundle for the MEM stage: EX/MEM input, data-memory port, MEM/WB output.
// The slave modport is the stage itself; master is the surrounding pipeline/memory side.
// No storage here; pure signal grouping.
interface mem_stage_if #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_is_load;
    logic             in_is_store;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_addr;
    logic [XLEN-1:0]  in_wdata;
    logic [XLEN-1:0]  in_alu_result;
    logic [TAG_W-1:0] in_tag;
    logic             in_rd_we;

    logic             mem_req;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_rd_we;
    logic             out_exc;

    modport slave (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
               in_alu_result, in_tag, in_rd_we,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output out_valid, out_data, out_tag, out_rd_we, out_exc,
        input  out_ready
    );

    modport master (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_wdata,
               in_alu_result, in_tag, in_rd_we,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  out_valid, out_data, out_tag, out_rd_we, out_exc,
        output out_ready
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: one op in flight; ALU pass-through, byte/half/word loads and stores via req/gnt/rvalid.
// Latency: ALU 1 cycle in_valid->out_valid, load 2 cycles with zero-wait memory; in_ready only in IDLE.
// Backpressure: result held stable in HOLD until out_ready. MEM_MISALIGN_TRAP_EN enables misalign traps.
module mem_stage #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
) (
    input logic      clk,
    input logic      rst,
    mem_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [TAG_W-1:0] tag_q;
    logic             rd_we_q;
    logic [XLEN-1:0]  data_q;
    logic             exc_q;

    logic             accept;
    logic             is_mem_op;
    logic             trap_hit;
    logic             load_done;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_data;
    logic [3:0]       be_w;
    logic [XLEN-1:0]  wdata_rep;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign is_mem_op = bus.in_is_load || bus.in_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    // Halfword at odd address or word off a word boundary never reaches memory.
    assign trap_hit = is_mem_op &&
                      (((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                       ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00)));
`else
    assign trap_hit = 1'b0;
`endif

    // REQ only ever holds loads or stores, so "not a store" means load here.
    assign load_done = ((state == REQ) && bus.mem_gnt && !is_store_q && bus.mem_rvalid) ||
                       ((state == WAIT) && bus.mem_rvalid);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: gnt only matters in REQ, rvalid only in REQ (same-cycle) and WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) begin
                if (trap_hit)       state_nxt = HOLD;
                else if (is_mem_op) state_nxt = REQ;
                else                state_nxt = HOLD;
            end
            REQ: if (bus.mem_gnt) begin
                if (is_store_q || bus.mem_rvalid) state_nxt = HOLD;
                else                              state_nxt = WAIT;
            end
            WAIT: if (bus.mem_rvalid) state_nxt = HOLD;
            HOLD: if (bus.out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept and load-result capture on return data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_q      <= '0;
            rd_we_q    <= 1'b0;
            data_q     <= '0;
            exc_q      <= 1'b0;
        end else begin
            if (accept) begin
                is_store_q <= bus.in_is_store && !bus.in_is_load;
                funct3_q   <= bus.in_funct3;
                addr_q     <= bus.in_addr;
                wdata_q    <= bus.in_wdata;
                tag_q      <= bus.in_tag;
                rd_we_q    <= bus.in_rd_we;
                data_q     <= trap_hit ? bus.in_addr : bus.in_alu_result;
                exc_q      <= trap_hit;
            end
            if (load_done) data_q <= load_data;
        end
    end

    // Bring the addressed lane down to bit 0, then extend by width/sign code.
    assign shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};

    // Load extraction; misaligned halfwords without trapping just lose the upper lane.
    always_comb begin
        load_data = bus.mem_rdata;
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // Byte enables and lane-replicated store data; shifts truncate to the 4-bit word.
    always_comb begin
        be_w      = 4'b1111;
        wdata_rep = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_w      = 4'b0001 << addr_q[1:0];
                wdata_rep = {(XLEN/8){wdata_q[7:0]}};
            end
            2'b01: begin
                be_w      = 4'b0011 << addr_q[1:0];
                wdata_rep = {(XLEN/16){wdata_q[15:0]}};
            end
            default: begin
                be_w      = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = (state == REQ) && is_store_q;
    assign bus.mem_be    = (state == REQ) ? be_w : 4'b0000;
    assign bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign bus.mem_wdata = wdata_rep;

    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_rd_we = rd_we_q && !is_store_q && !exc_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign bus.out_exc   = exc_q;
`else
    assign bus.out_exc   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, LB/SH/LHU/LW, backpressure, reset abort, misalign.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_stage;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    mem_stage_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus();

    mem_stage #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_is_store   = 1'b0;
        bus.in_funct3     = 3'b000;
        bus.in_addr       = '0;
        bus.in_wdata      = '0;
        bus.in_alu_result = '0;
        bus.in_tag        = '0;
        bus.in_rd_we      = 1'b0;
        bus.mem_gnt       = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic [5:0] tag, input logic we);
        bus.in_valid      = 1'b1;
        bus.in_is_load    = ld;
        bus.in_is_store   = st;
        bus.in_funct3     = f3;
        bus.in_addr       = addr;
        bus.in_wdata      = wd;
        bus.in_alu_result = alu;
        bus.in_tag        = tag;
        bus.in_rd_we      = we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0h expected 0", bus.out_valid); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %0h expected 0", bus.mem_req); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_mem_we: got %0h expected 0", bus.mem_we); else passed++;
        total++; if (bus.mem_be !== 4'b0000) $display("FAIL rst_mem_be: got %0h expected 0", bus.mem_be); else passed++;
        total++; if (bus.out_exc !== 1'b0) $display("FAIL rst_out_exc: got %0h expected 0", bus.out_exc); else passed++;
        total++; if (bus.out_data !== 32'h0) $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); else passed++;
        total++; if (bus.out_tag !== 6'h0) $display("FAIL rst_out_tag: got %0h expected 0", bus.out_tag); else passed++;
        total++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %0h expected 0", bus.mem_addr); else passed++;
        total++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %0h expected 0", bus.mem_wdata); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0h expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_alu();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234, 6'd5, 1'b1);
        bus.out_ready = 1'b1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL alu_in_ready: got %0h expected 1", bus.in_ready); else passed++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL alu_out_valid: got %0h expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 32'h1234) $display("FAIL alu_out_data: got %0h expected 1234", bus.out_data); else passed++;
        total++; if (bus.out_tag !== 6'd5) $display("FAIL alu_out_tag: got %0h expected 5", bus.out_tag); else passed++;
        total++; if (bus.out_rd_we !== 1'b1) $display("FAIL alu_out_rd_we: got %0h expected 1", bus.out_rd_we); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL alu_mem_req: got %0h expected 0", bus.mem_req); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL alu_in_ready_hold: got %0h expected 0", bus.in_ready); else passed++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL alu_done_valid: got %0h expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL alu_done_ready: got %0h expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_lb();
        issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'hDEAD, 6'd7, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.mem_req !== 1'b1) $display("FAIL lb_mem_req: got %0h expected 1", bus.mem_req); else passed++;
        total++; if (bus.mem_be !== 4'b1000) $display("FAIL lb_mem_be: got %b expected 1000", bus.mem_be); else passed++;
        total++; if (bus.mem_addr !== 32'h100) $display("FAIL lb_mem_addr: got %0h expected 100", bus.mem_addr); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL lb_mem_we: got %0h expected 0", bus.mem_we); else passed++;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h80FF_FF7F;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL lb_out_valid: got %0h expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 32'hFFFF_FF80) $display("FAIL lb_out_data: got %0h expected ffffff80", bus.out_data); else passed++;
        total++; if (bus.out_tag !== 6'd7) $display("FAIL lb_out_tag: got %0h expected 7", bus.out_tag); else passed++;
        total++; if (bus.out_rd_we !== 1'b1) $display("FAIL lb_out_rd_we: got %0h expected 1", bus.out_rd_we); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL lb_req_drop: got %0h expected 0", bus.mem_req); else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL lb_done_valid: got %0h expected 0", bus.out_valid); else passed++;
    endtask

    task automatic test_sh();
        issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 6'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            total++; if (bus.mem_req !== 1'b1) $display("FAIL sh_mem_req_%0d: got %0h expected 1", i, bus.mem_req); else passed++;
            total++; if (bus.mem_be !== 4'b1100) $display("FAIL sh_mem_be_%0d: got %b expected 1100", i, bus.mem_be); else passed++;
            total++; if (bus.mem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_mem_wdata_%0d: got %0h expected abcdabcd", i, bus.mem_wdata); else passed++;
            total++; if (bus.mem_we !== 1'b1) $display("FAIL sh_mem_we_%0d: got %0h expected 1", i, bus.mem_we); else passed++;
            if (i == 2) bus.mem_gnt = 1'b1;
        end
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL sh_out_valid: got %0h expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_rd_we !== 1'b0) $display("FAIL sh_out_rd_we: got %0h expected 0", bus.out_rd_we); else passed++;
        total++; if (bus.out_tag !== 6'd3) $display("FAIL sh_out_tag: got %0h expected 3", bus.out_tag); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL sh_req_drop: got %0h expected 0", bus.mem_req); else passed++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL sh_done_valid: got %0h expected 0", bus.out_valid); else passed++;
    endtask

    task automatic test_lhu();
        issue(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h0, 6'd9, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.mem_be !== 4'b0011) $display("FAIL lhu_mem_be: got %b expected 0011", bus.mem_be); else passed++;
        bus.mem_gnt = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus.mem_gnt = 1'b0;
            total++; if (bus.out_valid !== 1'b0) $display("FAIL lhu_wait_valid_%0d: got %0h expected 0", k, bus.out_valid); else passed++;
            total++; if (bus.mem_req !== 1'b0) $display("FAIL lhu_wait_req_%0d: got %0h expected 0", k, bus.mem_req); else passed++;
            if (k == 4) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'h1234_9ABC;
            end
        end
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'hFFFF_FFFF;
            total++; if (bus.out_valid !== 1'b1) $display("FAIL lhu_hold_valid_%0d: got %0h expected 1", m, bus.out_valid); else passed++;
            total++; if (bus.out_data !== 32'h0000_9ABC) $display("FAIL lhu_hold_data_%0d: got %0h expected 9abc", m, bus.out_data); else passed++;
            if (m == 2) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL lhu_done_valid: got %0h expected 0", bus.out_valid); else passed++;
        bus.mem_rvalid = 1'b1;
        bus.mem_gnt    = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_gnt    = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL idle_stray_valid: got %0h expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL idle_stray_ready: got %0h expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_rst_wait();
        issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 6'd4, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mem_gnt  = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL rw_in_wait_ready: got %0h expected 0", bus.in_ready); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL rw_in_wait_req: got %0h expected 0", bus.mem_req); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rw_out_valid: got %0h expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL rw_in_ready: got %0h expected 1", bus.in_ready); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL rw_mem_req: got %0h expected 0", bus.mem_req); else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rw_out_valid_late: got %0h expected 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 32'h0) $display("FAIL rw_out_data: got %0h expected 0", bus.out_data); else passed++;
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h11, 6'd1, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.out_data !== 32'h11) $display("FAIL b2b_first_data: got %0h expected 11", bus.out_data); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_first_ready: got %0h expected 0", bus.in_ready); else passed++;
        bus.in_alu_result = 32'h22;
        bus.in_tag        = 6'd2;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_gap_valid: got %0h expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_gap_ready: got %0h expected 1", bus.in_ready); else passed++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_second_valid: got %0h expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== 32'h22) $display("FAIL b2b_second_data: got %0h expected 22", bus.out_data); else passed++;
        total++; if (bus.out_tag !== 6'd2) $display("FAIL b2b_second_tag: got %0h expected 2", bus.out_tag); else passed++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_done_valid: got %0h expected 0", bus.out_valid); else passed++;
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hBEEF, 6'd6, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        total++; if (bus.mem_req !== 1'b0) $display("FAIL mis_mem_req: got %0h expected 0", bus.mem_req); else passed++;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL mis_out_valid: got %0h expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_exc !== 1'b1) $display("FAIL mis_out_exc: got %0h expected 1", bus.out_exc); else passed++;
        total++; if (bus.out_data !== 32'h101) $display("FAIL mis_out_data: got %0h expected 101", bus.out_data); else passed++;
        total++; if (bus.out_rd_we !== 1'b0) $display("FAIL mis_out_rd_we: got %0h expected 0", bus.out_rd_we); else passed++;
`else
        total++; if (bus.mem_req !== 1'b1) $display("FAIL mis_mem_req: got %0h expected 1", bus.mem_req); else passed++;
        total++; if (bus.mem_be !== 4'b1111) $display("FAIL mis_mem_be: got %b expected 1111", bus.mem_be); else passed++;
        total++; if (bus.mem_addr !== 32'h100) $display("FAIL mis_mem_addr: got %0h expected 100", bus.mem_addr); else passed++;
        bus.mem_gnt    = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5566_7788;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL mis_out_valid: got %0h expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_exc !== 1'b0) $display("FAIL mis_out_exc: got %0h expected 0", bus.out_exc); else passed++;
        total++; if (bus.out_data !== 32'h5566_7788) $display("FAIL mis_out_data: got %0h expected 55667788", bus.out_data); else passed++;
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mis_done_valid: got %0h expected 0", bus.out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb();
        test_sh();
        test_lhu();
        test_rst_wait();
        test_back_to_back();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
